// File: rtl/cas_tone_gen.sv
// cas_tone_gen -- byte-to-tape tone generator for cassette playback.
//
// Serialises one byte per start pulse LSB first onto dout. A 0 bit is one
// full cycle of 1200 Hz (HALF0 high, HALF0 low) and a 1 bit is one full
// cycle of 2400 Hz (HALF1 high, HALF1 low). A single-cycle done follows the
// last low half. All outputs are registered.
//
// Optional feature: define CAS_TONE_QUEUE_EN to add a one-byte holding
// register so a byte offered while busy is played back-to-back.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous, active-high
//   start  in  1  single-cycle request, din valid in the same cycle
//   din    in  8  byte to encode
//   done   out 1  single-cycle pulse when the byte has been emitted
//   dout   out 1  tape bit stream
//   busy   out 1  high from acceptance through the done cycle
module cas_tone_gen #(
  parameter int CLK_HZ = 28_636_360
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  output logic       done,
  output logic       dout,
  output logic       busy
);

  localparam int HALF0 = CLK_HZ / 2400;
  localparam int HALF1 = CLK_HZ / 4800;
  localparam int CW    = $clog2(HALF0 + 1);

  localparam logic [CW-1:0] H0   = CW'(HALF0);
  localparam logic [CW-1:0] H1   = CW'(HALF1);
  localparam logic [CW-1:0] TERM = CW'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t        state_q;
  logic [7:0]    sr_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          dout_q;
  logic          busy_q;

`ifdef CAS_TONE_QUEUE_EN
  logic [7:0]    qbyte_q;
  logic          qv_q;
  logic          q_store;

  // The holding register takes din while a byte is playing and the slot is
  // free, or in DONE when the held byte is being moved into the shifter.
  // A start in DONE with nothing held is accepted straight into the shifter.
  assign q_store = start &&
                   (((state_q == HIGH || state_q == LOW) && !qv_q) ||
                    (state_q == DONE && qv_q));
`endif

  // Half-period for the bit currently at the shifter LSB.
  function automatic logic [CW-1:0] half_of(input logic b);
    return b ? H1 : H0;
  endfunction

  // The counter is loaded with HALF and the half ends on the cycle it reads
  // 1, so each half is visible for exactly HALF clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CAS_TONE_QUEUE_EN
      qbyte_q <= '0;
      qv_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= din;
            idx_q   <= '0;
            cnt_q   <= half_of(din[0]);
            state_q <= HIGH;
            dout_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == TERM) begin
            cnt_q   <= half_of(sr_q[0]);
            state_q <= LOW;
            dout_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - TERM;
          end
        end
        LOW: begin
          if (cnt_q == TERM) begin
            if (idx_q == 3'd7) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              // Next bit is sr_q[1]; it becomes the LSB after this shift.
              sr_q    <= sr_q >> 1;
              idx_q   <= idx_q + 3'd1;
              cnt_q   <= half_of(sr_q[1]);
              state_q <= HIGH;
              dout_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - TERM;
          end
        end
        DONE: begin
`ifdef CAS_TONE_QUEUE_EN
          if (qv_q) begin
            sr_q    <= qbyte_q;
            idx_q   <= '0;
            cnt_q   <= half_of(qbyte_q[0]);
            state_q <= HIGH;
            dout_q  <= 1'b1;
            qv_q    <= 1'b0;
          end else if (start) begin
            sr_q    <= din;
            idx_q   <= '0;
            cnt_q   <= half_of(din[0]);
            state_q <= HIGH;
            dout_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
`ifdef CAS_TONE_QUEUE_EN
      // Placed after the case so a store in DONE wins over the slot release.
      if (q_store) begin
        qbyte_q <= din;
        qv_q    <= 1'b1;
      end
`endif
    end
  end

  assign done = done_q;
  assign dout = dout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cas_tone_gen.sv
module tb_cas_tone_gen;
  localparam int CLK_HZ = 48000;
  localparam int H0 = CLK_HZ / 2400;   // 20
  localparam int H1 = CLK_HZ / 4800;   // 10

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       done, dout, busy;

  cas_tone_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .done(done), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Expected per-cycle outputs, packed {busy, done, dout}.
  logic [2:0] expq[$];
  logic       cur_busy = 1'b0;
  logic       prev_busy = 1'b0;
  int         done_log[$];
  int         bfall_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: a byte plays as a plain list of per-cycle output triples.
  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      int h;
      h = b[k] ? H1 : H0;
      for (int i = 0; i < h; i++) expq.push_back(3'b101);
      for (int i = 0; i < h; i++) expq.push_back(3'b100);
    end
    expq.push_back(3'b110);
  endtask

  function automatic int streams_left();
    int n;
    n = 0;
    foreach (expq[i]) if (expq[i][1]) n++;
    return n;
  endfunction

  // Compare process: every cycle the DUT must match the model (idle when empty).
  always @(negedge clk) begin
    logic [2:0] e;
    e = (expq.size() > 0) ? expq.pop_front() : 3'b000;
    check("dout", 32'(dout), 32'(e[0]));
    check("done", 32'(done), 32'(e[1]));
    check("busy", 32'(busy), 32'(e[2]));
    cur_busy = e[2];
    if (done === 1'b1) done_log.push_back(cyc);
    if (prev_busy === 1'b1 && busy === 1'b0) bfall_log.push_back(cyc);
    prev_busy = busy;
  end

  // Called at negedge+1; start is sampled on the following rising edge.
  task automatic do_start(input logic [7:0] b);
    logic acc;
`ifdef CAS_TONE_QUEUE_EN
    acc = (streams_left() < 2);
`else
    acc = !cur_busy && (expq.size() == 0);
`endif
    start = 1'b1;
    din   = b;
    if (acc) push_byte(b);
    @(negedge clk); #1;
    start = 1'b0;
    din   = 8'h00;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (expq.size() > 0 && i < 2000) begin
      @(negedge clk); #1;
      i++;
    end
    check("drain_timeout", 32'(i < 2000), 32'(1));
    wait_cyc(3);
  endtask

  // One byte from idle: done offset T, busy fall offset T+1 from start edge.
  task automatic run_byte(input logic [7:0] b, input int t_exp);
    int n;
    done_log.delete();
    bfall_log.delete();
    do_start(b);
    n = cyc;
    drain();
    check("done_count", 32'(done_log.size()), 32'(1));
    if (done_log.size() > 0) check("done_time", 32'(done_log[0] - n), 32'(t_exp));
    if (bfall_log.size() > 0) check("busy_fall", 32'(bfall_log[0] - n), 32'(t_exp + 1));
    else check("busy_fall_seen", 32'(0), 32'(1));
  endtask

  initial begin
    int n;
    wait_cyc(3);
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    reset = 1'b0;
    wait_cyc(2);

    run_byte(8'h00, 320);
    run_byte(8'hFF, 160);
    run_byte(8'h01, 300);
    run_byte(8'h3C, 240);

`ifdef CAS_TONE_QUEUE_EN
    // Queue: 0x0F held and played back-to-back, 0x55 dropped (slot full).
    done_log.delete();
    bfall_log.delete();
    do_start(8'h00);
    n = cyc;
    wait_cyc(49);
    do_start(8'h0F);
    wait_cyc(9);
    do_start(8'h55);
    drain();
    check("q_done_count", 32'(done_log.size()), 32'(2));
    if (done_log.size() == 2) begin
      check("q_done1", 32'(done_log[0] - n), 32'(320));
      check("q_done2", 32'(done_log[1] - n), 32'(561));
    end
    check("q_busy_falls", 32'(bfall_log.size()), 32'(1));
    if (bfall_log.size() > 0) check("q_busy_fall", 32'(bfall_log[0] - n), 32'(562));
`else
    // Starts while busy and in the done cycle are ignored.
    done_log.delete();
    bfall_log.delete();
    do_start(8'h00);
    n = cyc;
    wait_cyc(49);
    do_start(8'hAA);
    wait_cyc(270);
    check("done_cycle_done", 32'(done), 32'(1));
    do_start(8'hAA);
    drain();
    check("ign_done_count", 32'(done_log.size()), 32'(1));
    if (done_log.size() > 0) check("ign_done", 32'(done_log[0] - n), 32'(320));
    if (bfall_log.size() > 0) check("ign_busy_fall", 32'(bfall_log[0] - n), 32'(321));
    else check("ign_busy_fall_seen", 32'(0), 32'(1));
`endif

    // Reset mid-byte: immediate abort, no done, then a clean byte.
    done_log.delete();
    do_start(8'h00);
    wait_cyc(99);
    reset = 1'b1;
    expq.delete();
    #1;
    check("abort_dout", 32'(dout), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    check("abort_no_done", 32'(done_log.size()), 32'(0));
    run_byte(8'hFF, 160);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
